// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared types, BCD constants and conversion helpers for the
//               alarm clock core. All time values are 2-digit packed BCD.
//               Contents:
//                 bcd8_t        - 2-digit packed BCD byte
//                 BCD_59/23/12  - counter limits and 12 h display value
//                 alarm_state_t - IDLE / RING / SNOOZE
//                 bcd_to_bin, bin_to_bcd, to12h
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    typedef logic [7:0] bcd8_t;

    localparam bcd8_t BCD_59 = 8'h59;
    localparam bcd8_t BCD_23 = 8'h23;
    localparam bcd8_t BCD_12 = 8'h12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_t;

    function automatic logic [6:0] bcd_to_bin(input bcd8_t b);
        return (7'(b[7:4]) * 7'd10) + 7'(b[3:0]);
    endfunction

    // Valid for 0..99 only, which covers every value this core stores.
    function automatic bcd8_t bin_to_bcd(input logic [6:0] v);
        logic [6:0] tens;
        logic [6:0] ones;
        tens = v / 7'd10;
        ones = v - (tens * 7'd10);
        return {tens[3:0], ones[3:0]};
    endfunction

    // Returns {pm, hour12}: midnight shows as 12 AM, noon as 12 PM.
    function automatic logic [8:0] to12h(input bcd8_t h24);
        logic [6:0] b;
        b = bcd_to_bin(h24);
        if (b == 7'd0) begin
            return {1'b0, BCD_12};
        end else if (b < 7'd12) begin
            return {1'b0, h24};
        end else if (b == 7'd12) begin
            return {1'b1, BCD_12};
        end else begin
            return {1'b1, bin_to_bcd(b - 7'd12)};
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_counter
// Description : 2-digit BCD counter wrapping at MAX. Each cycle it steps by
//               0, 1 or 2 (inc_carry + inc_user) modulo MAX+1. The carry
//               output reports only the wrap caused by inc_carry, so a user
//               edit never ripples into the next counter.
//   clk       in  system clock
//   clr       in  asynchronous active-high reset (value -> 00)
//   inc_carry in  carry from the lower counter / tick
//   inc_user  in  user edit pulse
//   o_value   out current BCD value
//   carry     out inc_carry while value == MAX
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter
    import clock_pkg::*;
#(
    parameter bcd8_t MAX = BCD_59
) (
    input  logic  clk,
    input  logic  clr,
    input  logic  inc_carry,
    input  logic  inc_user,
    output bcd8_t o_value,
    output logic  carry
);

    localparam logic [6:0] c_MAX_BIN = bcd_to_bin(MAX);

    bcd8_t      r_value;
    logic [6:0] w_raw;
    logic [6:0] w_wrapped;

    always_comb begin
        w_raw     = bcd_to_bin(r_value) + {6'd0, inc_carry} + {6'd0, inc_user};
        w_wrapped = w_raw;
        if (w_raw > c_MAX_BIN) begin
            w_wrapped = w_raw - (c_MAX_BIN + 7'd1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_value <= 8'h00;
        end else begin
            r_value <= bin_to_bcd(w_wrapped);
        end
    end

    assign o_value = r_value;
    assign carry   = inc_carry && (r_value == MAX);

endmodule
`default_nettype wire

// File: rtl/alarm_clock_core.sv
`default_nettype none
// ============================================================================
// Module      : alarm_clock_core
// Description : BCD HH:MM:SS time-of-day with 12/24 h view, settable alarm
//               with ring / snooze / auto-off, and a 1 Hz tick derived from
//               a CLK_HZ input clock.
//   clk, clr          clock, asynchronous active-high reset
//   enable            1 = prescaler and tick-driven logic run
//   hourMode          0 = 24 h view, 1 = 12 h view
//   sel_alarm         0 = edit/show time, 1 = edit/show alarm
//   madd, hadd        one-cycle minute / hour +1 pulses
//   alarm_en          alarm armed
//   snooze, stop      one-cycle ring control pulses
//   osecond/ominute/ohour  BCD outputs of the selected view
//   pm                12 h view afternoon flag
//   ringing           alarm sounding
//   tick_1hz          registered pulse on each prescaler wrap
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_clock_core
    import clock_pkg::*;
#(
    parameter int CLK_HZ     = 1000000,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       enable,
    input  logic       hourMode,
    input  logic       sel_alarm,
    input  logic       madd,
    input  logic       hadd,
    input  logic       alarm_en,
    input  logic       snooze,
    input  logic       stop,
    output logic [7:0] osecond,
    output logic [7:0] ominute,
    output logic [7:0] ohour,
    output logic       pm,
    output logic       ringing,
    output logic       tick_1hz
);

    localparam int                  c_PRE_W       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_PRE_W-1:0]  c_PRE_MAX     = c_PRE_W'(CLK_HZ - 1);
    localparam logic [7:0]          c_RING_LOAD   = 8'(RING_SEC);
    localparam logic [11:0]         c_SNOOZE_LOAD = 12'(SNOOZE_MIN * 60);

    // ------------------------------------------------------------------
    // Prescaler and 1 Hz tick
    // ------------------------------------------------------------------
    logic [c_PRE_W-1:0] r_pre;
    logic               r_tick_1hz;
    logic               w_tick;

    assign w_tick = enable && (r_pre == c_PRE_MAX);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pre      <= '0;
            r_tick_1hz <= 1'b0;
        end else begin
            r_tick_1hz <= w_tick;
            if (enable) begin
                r_pre <= w_tick ? '0 : r_pre + c_PRE_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Time and alarm registers (24 h BCD)
    // ------------------------------------------------------------------
    bcd8_t w_sec, w_min, w_hour, w_amin, w_ahour;
    logic  w_sec_carry, w_min_carry;
    logic  w_unused_hour_carry, w_unused_amin_carry, w_unused_ahour_carry;

    bcd_counter #(.MAX(BCD_59)) u_sec (
        .clk       (clk),
        .clr       (clr),
        .inc_carry (w_tick),
        .inc_user  (1'b0),
        .o_value   (w_sec),
        .carry     (w_sec_carry)
    );

    bcd_counter #(.MAX(BCD_59)) u_min (
        .clk       (clk),
        .clr       (clr),
        .inc_carry (w_sec_carry),
        .inc_user  (madd && !sel_alarm),
        .o_value   (w_min),
        .carry     (w_min_carry)
    );

    bcd_counter #(.MAX(BCD_23)) u_hour (
        .clk       (clk),
        .clr       (clr),
        .inc_carry (w_min_carry),
        .inc_user  (hadd && !sel_alarm),
        .o_value   (w_hour),
        .carry     (w_unused_hour_carry)
    );

    bcd_counter #(.MAX(BCD_59)) u_amin (
        .clk       (clk),
        .clr       (clr),
        .inc_carry (1'b0),
        .inc_user  (madd && sel_alarm),
        .o_value   (w_amin),
        .carry     (w_unused_amin_carry)
    );

    bcd_counter #(.MAX(BCD_23)) u_ahour (
        .clk       (clk),
        .clr       (clr),
        .inc_carry (1'b0),
        .inc_user  (hadd && sel_alarm),
        .o_value   (w_ahour),
        .carry     (w_unused_ahour_carry)
    );

    // ------------------------------------------------------------------
    // Alarm FSM
    // ------------------------------------------------------------------
    alarm_state_t r_state, w_state_n;
    logic [7:0]   r_ring_cnt, w_ring_cnt_n;
    logic [11:0]  r_snz_cnt,  w_snz_cnt_n;
    logic         w_match;

    // The tick that just landed on HH:MM:00 is still visible as r_tick_1hz,
    // so the comparison runs one cycle after the time update. Edits cannot
    // trigger the alarm because they never raise r_tick_1hz.
    assign w_match = r_tick_1hz && (w_sec == 8'h00) &&
                     (w_min == w_amin) && (w_hour == w_ahour);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= IDLE;
            r_ring_cnt <= 8'd0;
            r_snz_cnt  <= 12'd0;
        end else begin
            r_state    <= w_state_n;
            r_ring_cnt <= w_ring_cnt_n;
            r_snz_cnt  <= w_snz_cnt_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_ring_cnt_n = r_ring_cnt;
        w_snz_cnt_n  = r_snz_cnt;
        if (!alarm_en) begin
            w_state_n = IDLE;
        end else if (enable) begin
            case (r_state)
                IDLE: begin
                    if (w_match) begin
                        w_state_n    = RING;
                        w_ring_cnt_n = c_RING_LOAD;
                    end
                end
                RING: begin
                    if (stop) begin
                        w_state_n = IDLE;
                    end else if (snooze) begin
                        w_state_n   = SNOOZE;
                        w_snz_cnt_n = c_SNOOZE_LOAD;
                    end else if (w_tick) begin
                        w_ring_cnt_n = r_ring_cnt - 8'd1;
                        if (r_ring_cnt <= 8'd1) begin
                            w_state_n    = IDLE;
                            w_ring_cnt_n = 8'd0;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop) begin
                        w_state_n = IDLE;
                    end else if (w_tick) begin
                        w_snz_cnt_n = r_snz_cnt - 12'd1;
                        if (r_snz_cnt <= 12'd1) begin
                            w_state_n    = RING;
                            w_snz_cnt_n  = 12'd0;
                            w_ring_cnt_n = c_RING_LOAD;
                        end
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output view
    // ------------------------------------------------------------------
    bcd8_t      w_view_min, w_view_hour;
    logic [8:0] w_h12;

    always_comb begin
        w_view_min  = sel_alarm ? w_amin  : w_min;
        w_view_hour = sel_alarm ? w_ahour : w_hour;
        w_h12       = to12h(w_view_hour);
        osecond     = sel_alarm ? 8'h00 : w_sec;
        ominute     = w_view_min;
        ohour       = hourMode ? w_h12[7:0] : w_view_hour;
        pm          = hourMode && w_h12[8];
    end

    assign ringing  = (r_state == RING);
    assign tick_1hz = r_tick_1hz;

endmodule
`default_nettype wire

// File: tb/tb_alarm_clock_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_clock_core
// Description : Self-checking bench for alarm_clock_core (CLK_HZ=10,
//               SNOOZE_MIN=1, RING_SEC=3). A seconds/minutes-of-day model
//               predicts every output each cycle; directed steps add
//               constant checks at the interesting points, then a random
//               phase exercises all inputs together.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_clock_core;

    localparam int CLK_HZ     = 10;
    localparam int SNOOZE_MIN = 1;
    localparam int RING_SEC   = 3;

    logic       clk = 1'b0;
    logic       clr, enable, hourMode, sel_alarm, madd, hadd, alarm_en, snooze, stop;
    logic [7:0] osecond, ominute, ohour;
    logic       pm, ringing, tick_1hz;

    int compared   = 0;
    int mismatched = 0;

    // reference model state: plain integers
    int m_pre, m_s, m_m, m_h, m_am, m_ah, m_st, m_ring, m_snz;
    bit m_tick1;

    always #5 clk = ~clk;

    alarm_clock_core #(
        .CLK_HZ     (CLK_HZ),
        .SNOOZE_MIN (SNOOZE_MIN),
        .RING_SEC   (RING_SEC)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .enable    (enable),
        .hourMode  (hourMode),
        .sel_alarm (sel_alarm),
        .madd      (madd),
        .hadd      (hadd),
        .alarm_en  (alarm_en),
        .snooze    (snooze),
        .stop      (stop),
        .osecond   (osecond),
        .ominute   (ominute),
        .ohour     (ohour),
        .pm        (pm),
        .ringing   (ringing),
        .tick_1hz  (tick_1hz)
    );

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_expired(input string tag, input bit reached);
        if (!reached) begin
            compared++;
            mismatched++;
            $error("FAIL %s: observed timeout expected event", tag);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_s = 0; m_m = 0; m_h = 0; m_am = 0; m_ah = 0;
        m_st = 0; m_ring = 0; m_snz = 0; m_tick1 = 0;
    endtask

    // One rising edge of the specified behaviour (state 0=idle 1=ring 2=snooze).
    task automatic model_step();
        bit match, tk, sw, mw;
        match = m_tick1 && (m_s == 0) && (m_m == m_am) && (m_h == m_ah);
        tk    = enable && (m_pre == CLK_HZ - 1);
        if (enable) m_pre = (m_pre + 1) % CLK_HZ;
        sw  = tk && (m_s == 59);
        mw  = sw && (m_m == 59);
        m_s = (m_s + (tk ? 1 : 0)) % 60;
        m_m = (m_m + (sw ? 1 : 0) + ((madd && !sel_alarm) ? 1 : 0)) % 60;
        m_h = (m_h + (mw ? 1 : 0) + ((hadd && !sel_alarm) ? 1 : 0)) % 24;
        if (madd && sel_alarm) m_am = (m_am + 1) % 60;
        if (hadd && sel_alarm) m_ah = (m_ah + 1) % 24;
        if (!alarm_en) begin
            m_st = 0;
        end else if (enable) begin
            if (m_st == 0) begin
                if (match) begin m_st = 1; m_ring = RING_SEC; end
            end else if (stop) begin
                m_st = 0;
            end else if (m_st == 1) begin
                if (snooze) begin
                    m_st = 2; m_snz = SNOOZE_MIN * 60;
                end else if (tk) begin
                    m_ring--;
                    if (m_ring == 0) m_st = 0;
                end
            end else if (tk) begin
                m_snz--;
                if (m_snz == 0) begin m_st = 1; m_ring = RING_SEC; end
            end
        end
        m_tick1 = tk;
    endtask

    task automatic check_all(input string where);
        int hv, h12;
        hv  = sel_alarm ? m_ah : m_h;
        h12 = (hv % 12 == 0) ? 12 : (hv % 12);
        chk({where, "/osecond"},  osecond,  sel_alarm ? 8'h00 : bcd(m_s));
        chk({where, "/ominute"},  ominute,  bcd(sel_alarm ? m_am : m_m));
        chk({where, "/ohour"},    ohour,    bcd(hourMode ? h12 : hv));
        chk({where, "/pm"},       8'(pm),   8'(hourMode && (hv >= 12)));
        chk({where, "/ringing"},  8'(ringing),  8'(m_st == 1));
        chk({where, "/tick_1hz"}, 8'(tick_1hz), 8'(m_tick1));
    endtask

    task automatic cycle(input string where);
        @(posedge clk);
        model_step();
        #1;
        check_all(where);
        madd = 1'b0; hadd = 1'b0; snooze = 1'b0; stop = 1'b0;
    endtask

    task automatic do_madd(input int n);
        for (int i = 0; i < n; i++) begin madd = 1'b1; cycle("madd"); end
    endtask

    task automatic do_hadd(input int n);
        for (int i = 0; i < n; i++) begin hadd = 1'b1; cycle("hadd"); end
    endtask

    initial begin
        int ticks, hb;
        bit reached;

        clr = 1'b1; enable = 1'b0; hourMode = 1'b0; sel_alarm = 1'b0;
        madd = 1'b0; hadd = 1'b0; alarm_en = 1'b0; snooze = 1'b0; stop = 1'b0;
        model_reset();

        // ---- reset state ----
        #2;
        chk("rst_osecond", osecond, 8'h00);
        chk("rst_ominute", ominute, 8'h00);
        chk("rst_ohour24", ohour, 8'h00);
        chk("rst_ringing", 8'(ringing), 8'h00);
        chk("rst_tick", 8'(tick_1hz), 8'h00);
        hourMode = 1'b1;
        #1;
        chk("rst_ohour12", ohour, 8'h12);
        chk("rst_pm", 8'(pm), 8'h00);
        hourMode = 1'b0;
        #9;
        clr = 1'b0; enable = 1'b1;

        // ---- first tick on the 10th enabled edge ----
        for (int i = 1; i <= CLK_HZ; i++) begin
            cycle("first_tick");
            chk("first_tick_pulse", 8'(tick_1hz), (i == CLK_HZ) ? 8'h01 : 8'h00);
        end
        chk("first_tick_sec", osecond, 8'h01);

        // ---- rollover 23:59:59 -> 00:00:00 ----
        enable = 1'b0;
        do_hadd(23);
        do_madd(59);
        enable = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (m_h == 23 && m_m == 59 && m_s == 59 && m_pre == CLK_HZ - 1) begin
                reached = 1'b1; break;
            end
            cycle("roll_wait");
        end
        wait_expired("roll_wait", reached);
        hourMode = 1'b1;
        cycle("rollover");
        chk("roll_sec", osecond, 8'h00);
        chk("roll_min", ominute, 8'h00);
        chk("roll_hour12", ohour, 8'h12);
        chk("roll_pm", 8'(pm), 8'h00);
        hourMode = 1'b0;
        #1;
        chk("roll_hour24", ohour, 8'h00);

        // ---- coincident tick carry and madd: 10:59:59 -> 11:01:00 ----
        enable = 1'b0;
        do_hadd(10);
        do_madd(59);
        enable = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (m_s == 59 && m_pre == CLK_HZ - 1) begin reached = 1'b1; break; end
            cycle("coin_wait");
        end
        wait_expired("coin_wait", reached);
        madd = 1'b1;
        cycle("coincident");
        chk("coin_sec", osecond, 8'h00);
        chk("coin_min", ominute, 8'h01);
        chk("coin_hour", ohour, 8'h11);

        // ---- plain madd at 10:58:30 does not touch the hour ----
        enable = 1'b0;
        do_hadd(23);
        do_madd(57);
        enable = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (m_s == 30) begin reached = 1'b1; break; end
            cycle("edit_wait");
        end
        wait_expired("edit_wait", reached);
        enable = 1'b0;
        madd = 1'b1;
        cycle("edit58");
        chk("edit_min", ominute, 8'h59);
        chk("edit_hour", ohour, 8'h10);
        chk("edit_sec", osecond, 8'h30);

        // ---- alarm 07:30, ring, auto-off after 3 ticks ----
        sel_alarm = 1'b1;
        do_hadd(7);
        do_madd(30);
        chk("alarm_view_hour", ohour, 8'h07);
        chk("alarm_view_min", ominute, 8'h30);
        chk("alarm_view_sec", osecond, 8'h00);
        sel_alarm = 1'b0;
        do_hadd(21);
        do_madd(30);
        alarm_en = 1'b1;
        enable = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (m_s == 59 && m_pre == CLK_HZ - 1) begin reached = 1'b1; break; end
            cycle("ring_wait");
        end
        wait_expired("ring_wait", reached);
        cycle("match_tick");
        chk("match_tick_pulse", 8'(tick_1hz), 8'h01);
        chk("match_not_yet", 8'(ringing), 8'h00);
        chk("match_min", ominute, 8'h30);
        cycle("ring_rise");
        chk("ring_rise", 8'(ringing), 8'h01);
        ticks = 0;
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_st != 1) begin reached = 1'b1; break; end
            cycle("ring_run");
            if (tick_1hz) ticks++;
        end
        wait_expired("auto_off_wait", reached);
        chk("auto_off_ticks", 8'(ticks), 8'd3);
        chk("auto_off_ringing", 8'(ringing), 8'h00);

        // ---- snooze cycle: alarm 07:31 ----
        sel_alarm = 1'b1;
        do_madd(1);
        sel_alarm = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (m_st == 1) begin reached = 1'b1; break; end
            cycle("ring2_wait");
        end
        wait_expired("ring2_wait", reached);
        chk("ring2", 8'(ringing), 8'h01);
        snooze = 1'b1;
        cycle("snooze");
        chk("snooze_quiet", 8'(ringing), 8'h00);
        ticks = 0;
        reached = 1'b0;
        for (int i = 0; i < 800; i++) begin
            cycle("snooze_run");
            if (tick_1hz) ticks++;
            if (m_st == 1) begin reached = 1'b1; break; end
        end
        wait_expired("snooze_wait", reached);
        chk("snooze_ticks", 8'(ticks), 8'd60);
        chk("snooze_rering", 8'(ringing), 8'h01);
        stop = 1'b1; snooze = 1'b1;
        cycle("stop_and_snooze");
        chk("stop_wins", 8'(ringing), 8'h00);
        for (int i = 0; i < 700; i++) cycle("after_stop");
        chk("stop_stays_idle", 8'(ringing), 8'h00);

        // ---- disable mid-ring, hadd while disabled, async clr ----
        sel_alarm = 1'b1;
        for (int i = 0; i < 60 && m_am != (m_m + 1) % 60; i++) begin madd = 1'b1; cycle("set_am"); end
        for (int i = 0; i < 24 && m_ah != m_h; i++) begin hadd = 1'b1; cycle("set_ah"); end
        sel_alarm = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (m_st == 1) begin reached = 1'b1; break; end
            cycle("ring3_wait");
        end
        wait_expired("ring3_wait", reached);
        enable = 1'b0;
        for (int i = 0; i < 3 * CLK_HZ; i++) cycle("disabled");
        chk("disabled_ringing", 8'(ringing), 8'h01);
        chk("disabled_no_tick", 8'(tick_1hz), 8'h00);
        hb = m_h;
        hadd = 1'b1;
        cycle("disabled_hadd");
        chk("disabled_hadd", ohour, bcd((hb + 1) % 24));
        #2;
        clr = 1'b1;
        #1;
        chk("clr_ringing", 8'(ringing), 8'h00);
        chk("clr_sec", osecond, 8'h00);
        chk("clr_min", ominute, 8'h00);
        chk("clr_hour", ohour, 8'h00);
        model_reset();
        @(negedge clk);
        clr = 1'b0;
        enable = 1'b1;

        // ---- randomized phase against the model ----
        sel_alarm = 1'b1;
        do_madd(1);
        sel_alarm = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            enable    = ($urandom_range(0, 19) != 0);
            madd      = ($urandom_range(0, 199) == 0);
            hadd      = ($urandom_range(0, 399) == 0);
            snooze    = ($urandom_range(0, 59) == 0);
            stop      = ($urandom_range(0, 89) == 0);
            if ($urandom_range(0, 99) == 0) sel_alarm = ~sel_alarm;
            if ($urandom_range(0, 49) == 0) hourMode  = ~hourMode;
            alarm_en  = ($urandom_range(0, 299) != 0);
            cycle("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
